// File: rtl/bus_pkg.sv
// ----------------------------------------------------------------------------
// bus_pkg
// Shared definitions for the serial system bus ports. The master receive port
// and the slave transmit port both take their frame width from here, so the
// two ends of the link agree on the frame size.
//   bus_state_t         : receive-port state encoding (IDLE, WAIT_HS, RECEIVE)
//   BUS_DATA_WIDTH      : default bits per serial frame
//   BUS_TIMEOUT_CYCLES  : default handshake timeout, in clock edges
//   bitCntWidth()       : width of a bit counter that can count to w
// ----------------------------------------------------------------------------
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_HS = 2'd1,
        RECEIVE = 2'd2
    } bus_state_t;

    localparam int BUS_DATA_WIDTH     = 8;
    localparam int BUS_TIMEOUT_CYCLES = 255;

    // One extra bit over clog2 so the counter can hold the full width value
    // without wrapping inside a frame.
    function automatic int bitCntWidth(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/serial_shift_in.sv
// ----------------------------------------------------------------------------
// serial_shift_in
// LSB-first deserialiser with its own bit counter. Each load writes bit_i into
// word position count and advances the counter. Clear has priority over load
// and zeroes both the word and the counter.
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   clear_i      : discard the partial word and restart at bit 0
//   load_i       : sample bit_i into the current bit position
//   bit_i        : serial input bit
//   assembled_o  : stored word with bit_i already merged at the current
//                  position, so the final bit is visible on the edge it is sampled
//   last_o       : the current position is the last bit of the frame
// ----------------------------------------------------------------------------
module serial_shift_in
    import bus_pkg::*;
#(
    parameter int DATA_WIDTH = BUS_DATA_WIDTH
)(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear_i,
    input  logic                  load_i,
    input  logic                  bit_i,
    output logic [DATA_WIDTH-1:0] assembled_o,
    output logic                  last_o
);

    localparam int CNT_W = bitCntWidth(DATA_WIDTH);

    logic [DATA_WIDTH-1:0] word_q;
    logic [DATA_WIDTH-1:0] word_d;
    logic [CNT_W-1:0]      count_q;
    logic [CNT_W-1:0]      count_d;
    logic [DATA_WIDTH-1:0] assembled;

    // Merge the incoming bit at the counter position, then pick next state.
    always_comb begin
        assembled = word_q;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (count_q == CNT_W'(i)) begin
                assembled[i] = bit_i;
            end
        end

        word_d  = word_q;
        count_d = count_q;
        if (clear_i) begin
            word_d  = '0;
            count_d = '0;
        end else if (load_i) begin
            word_d  = assembled;
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_q  <= '0;
            count_q <= '0;
        end else begin
            word_q  <= word_d;
            count_q <= count_d;
        end
    end

    assign assembled_o = assembled;
    assign last_o      = (count_q == CNT_W'(DATA_WIDTH - 1));

endmodule

// File: rtl/master_in_port.sv
// ----------------------------------------------------------------------------
// master_in_port
// Master-side serial receive port. On a core request it raises master_ready,
// waits for slave_ready, then deserialises DATA_WIDTH bits LSB first. The
// slave's done strobe must coincide with the last bit; anything else is a
// framing error and the partial word is discarded.
// Optional build macro: MASTER_IN_TIMEOUT_EN adds a handshake timeout of
// TIMEOUT_CYCLES edges; without it WAIT_HS waits forever and timeout_err is 0.
// Ports:
//   clk, reset     : clock, asynchronous active-high reset
//   rx_start       : request one frame (only looked at in IDLE)
//   slave_ready    : slave has data to send
//   rx_data        : serial data bit from the slave
//   slave_tx_done  : slave marks its last bit
//   master_ready   : registered, high while waiting for the handshake
//   busy           : any state other than IDLE
//   data_out       : last good word, held until the next good frame
//   data_valid     : one-cycle pulse when data_out updates
//   frame_err      : one-cycle pulse on a framing violation
//   timeout_err    : one-cycle pulse on handshake timeout
// ----------------------------------------------------------------------------
module master_in_port
    import bus_pkg::*;
#(
    parameter int DATA_WIDTH = BUS_DATA_WIDTH
`ifdef MASTER_IN_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = BUS_TIMEOUT_CYCLES
`endif
)(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx_start,
    input  logic                  slave_ready,
    input  logic                  rx_data,
    input  logic                  slave_tx_done,
    output logic                  master_ready,
    output logic                  busy,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  frame_err,
    output logic                  timeout_err
);

    bus_state_t            state_q;
    logic                  masterReady_q;
    logic [DATA_WIDTH-1:0] dataOut_q;
    logic                  dataValid_q;
    logic                  frameErr_q;

    logic                  handshake;
    logic                  shiftClear;
    logic                  shiftLoad;
    logic                  lastBit;
    logic [DATA_WIDTH-1:0] assembled;

    // The shift register restarts on the handshake edge and is discarded at
    // the end of every frame, good or bad, so no stale bits carry over.
    always_comb begin
        handshake  = (state_q == WAIT_HS) && slave_ready && masterReady_q;
        shiftLoad  = (state_q == RECEIVE);
        shiftClear = handshake || ((state_q == RECEIVE) && (lastBit || slave_tx_done));
    end

    serial_shift_in #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_shift (
        .clk         (clk),
        .reset       (reset),
        .clear_i     (shiftClear),
        .load_i      (shiftLoad),
        .bit_i       (rx_data),
        .assembled_o (assembled),
        .last_o      (lastBit)
    );

`ifdef MASTER_IN_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] toCnt_q;
    logic            timeoutErr_q;
`endif

    // Control FSM. Pulses default low every edge so each lasts one cycle.
    // A handshake is checked before the timeout so it wins on a tie.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            masterReady_q <= 1'b0;
            dataOut_q     <= '0;
            dataValid_q   <= 1'b0;
            frameErr_q    <= 1'b0;
`ifdef MASTER_IN_TIMEOUT_EN
            toCnt_q       <= '0;
            timeoutErr_q  <= 1'b0;
`endif
        end else begin
            dataValid_q <= 1'b0;
            frameErr_q  <= 1'b0;
`ifdef MASTER_IN_TIMEOUT_EN
            timeoutErr_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (rx_start) begin
                        state_q       <= WAIT_HS;
                        masterReady_q <= 1'b1;
`ifdef MASTER_IN_TIMEOUT_EN
                        toCnt_q       <= '0;
`endif
                    end
                end
                WAIT_HS: begin
                    if (handshake) begin
                        state_q       <= RECEIVE;
                        masterReady_q <= 1'b0;
                    end
`ifdef MASTER_IN_TIMEOUT_EN
                    else if (toCnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        state_q       <= IDLE;
                        masterReady_q <= 1'b0;
                        timeoutErr_q  <= 1'b1;
                    end else begin
                        toCnt_q <= toCnt_q + TO_W'(1);
                    end
`endif
                end
                RECEIVE: begin
                    if (lastBit) begin
                        state_q <= IDLE;
                        if (slave_tx_done) begin
                            dataOut_q   <= assembled;
                            dataValid_q <= 1'b1;
                        end else begin
                            frameErr_q <= 1'b1;
                        end
                    end else if (slave_tx_done) begin
                        state_q    <= IDLE;
                        frameErr_q <= 1'b1;
                    end
                end
                default: begin
                    state_q       <= IDLE;
                    masterReady_q <= 1'b0;
                end
            endcase
        end
    end

    assign master_ready = masterReady_q;
    assign busy         = (state_q != IDLE);
    assign data_out     = dataOut_q;
    assign data_valid   = dataValid_q;
    assign frame_err    = frameErr_q;
`ifdef MASTER_IN_TIMEOUT_EN
    assign timeout_err  = timeoutErr_q;
`else
    assign timeout_err  = 1'b0;
`endif

endmodule

// File: tb/tb_master_in_port.sv
// ----------------------------------------------------------------------------
// tb_master_in_port
// Directed bench for master_in_port. The stimulus task pushes the expected
// result pulse (kind, data_out, cycle) into a queue; an independent monitor
// pops an entry whenever data_valid, frame_err or timeout_err is seen.
// Build with MASTER_IN_TIMEOUT_EN to exercise the timeout with 4 cycles.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_master_in_port;

    localparam int DW = 8;

    typedef struct {
        int         kind;
        logic [7:0] data;
        int         cycle;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          rx_start;
    logic          slave_ready;
    logic          rx_data;
    logic          slave_tx_done;
    logic          master_ready;
    logic          busy;
    logic [DW-1:0] data_out;
    logic          data_valid;
    logic          frame_err;
    logic          timeout_err;

    int         compared   = 0;
    int         mismatched = 0;
    int         cycleCnt   = 0;
    logic [7:0] lastGood   = 8'h00;
    exp_t       expQ[$];

    master_in_port #(
        .DATA_WIDTH (DW)
`ifdef MASTER_IN_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES (4)
`endif
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .rx_start      (rx_start),
        .slave_ready   (slave_ready),
        .rx_data       (rx_data),
        .slave_tx_done (slave_tx_done),
        .master_ready  (master_ready),
        .busy          (busy),
        .data_out      (data_out),
        .data_valid    (data_valid),
        .frame_err     (frame_err),
        .timeout_err   (timeout_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cycleCnt);
        end
    endtask

    // Monitor: every result pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!reset && (data_valid || frame_err || timeout_err)) begin
            exp_t e;
            int   kindSeen;
            kindSeen = data_valid ? 0 : (frame_err ? 1 : 2);
            if (data_valid && frame_err)
                checkOutput("valid_err_exclusive", 32'd1, 32'd0);
            if (expQ.size() == 0) begin
                checkOutput("unexpected_pulse_kind", kindSeen, 32'hFFFF_FFFF);
            end else begin
                e = expQ.pop_front();
                checkOutput("pulse_kind", kindSeen, e.kind);
                checkOutput("pulse_data_out", data_out, e.data);
                checkOutput("pulse_cycle", cycleCnt, e.cycle);
            end
        end
    end

    // One frame. doneIdx: bit carrying slave_tx_done (-1 none). extraStartIdx:
    // bit during which rx_start is pulsed (-1 none). abortIdx: reset asserted
    // after this bit is sampled (-1 none). started: rx_start already high.
    // chain: leave rx_start high in the result cycle. hsDelay: extra cycles
    // in WAIT_HS before slave_ready.
    task automatic applyStimulus(input logic [7:0] word, input int doneIdx,
                                 input int extraStartIdx, input int abortIdx,
                                 input bit started, input bit chain, input int hsDelay);
        int   cH;
        int   lastIdx;
        bit   aborted;
        exp_t e;
        aborted = 0;
        if (!started) begin
            @(negedge clk);
            rx_start = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        rx_start = 1'b0;
        checkOutput("wait_master_ready", master_ready, 1);
        checkOutput("wait_busy", busy, 1);
        repeat (hsDelay) @(negedge clk);
        slave_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cH = cycleCnt;
        checkOutput("hs_master_ready", master_ready, 0);
        checkOutput("hs_busy", busy, 1);
        lastIdx = (doneIdx >= 0 && doneIdx < DW - 1) ? doneIdx : DW - 1;
        if (abortIdx < 0) begin
            e.kind  = (doneIdx == DW - 1) ? 0 : 1;
            e.data  = (doneIdx == DW - 1) ? word : lastGood;
            e.cycle = cH + 1 + lastIdx;
            expQ.push_back(e);
            if (doneIdx == DW - 1) lastGood = word;
        end
        for (int i = 0; i <= lastIdx; i++) begin
            rx_data       = word[i];
            slave_tx_done = (i == doneIdx);
            rx_start      = (i == extraStartIdx);
            slave_ready   = (i == 0);
            @(posedge clk);
            @(negedge clk);
            if (i == abortIdx) begin
                reset = 1'b1;
                #1;
                checkOutput("rst_data_out", data_out, 0);
                checkOutput("rst_master_ready", master_ready, 0);
                checkOutput("rst_busy", busy, 0);
                checkOutput("rst_data_valid", data_valid, 0);
                checkOutput("rst_frame_err", frame_err, 0);
                checkOutput("rst_timeout_err", timeout_err, 0);
                @(negedge clk);
                reset    = 1'b0;
                lastGood = 8'h00;
                aborted  = 1;
                break;
            end
        end
        rx_data       = 1'b0;
        slave_tx_done = 1'b0;
        slave_ready   = 1'b0;
        rx_start      = chain;
        if (!aborted) checkOutput("end_busy_idle", busy, 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish (compared %0d)", compared);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset         = 1'b1;
        rx_start      = 1'b0;
        slave_ready   = 1'b0;
        rx_data       = 1'b0;
        slave_tx_done = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_master_ready", master_ready, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_data_out", data_out, 0);
        checkOutput("reset_pulses", {data_valid, frame_err, timeout_err}, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        $display("[TB] nominal frame 0xA5");
        applyStimulus(8'hA5, 7, -1, -1, 0, 0, 1);
        $display("[TB] early done on bit 3 of 0x3C");
        applyStimulus(8'h3C, 3, -1, -1, 0, 0, 1);
        $display("[TB] missing done on 0x96");
        applyStimulus(8'h96, -1, -1, -1, 0, 0, 1);
        repeat (2) @(negedge clk);
        checkOutput("hold_data_out", data_out, 8'hA5);

        $display("[TB] reset after bit 4 of 0xFF, then 0x01");
        applyStimulus(8'hFF, 7, -1, 4, 0, 0, 1);
        applyStimulus(8'h01, 7, -1, -1, 0, 0, 1);

        $display("[TB] back-to-back 0x55 / 0xAA with mid-frame request");
        applyStimulus(8'h55, 7, -1, -1, 0, 1, 1);
        applyStimulus(8'hAA, 7, 3, -1, 1, 0, 1);
        @(negedge clk);
        checkOutput("b2b_idle_after", busy, 0);

`ifdef MASTER_IN_TIMEOUT_EN
        begin
            int   c0;
            exp_t e;
            $display("[TB] handshake timeout, 4 cycles");
            @(negedge clk);
            rx_start = 1'b1;
            @(posedge clk);
            @(negedge clk);
            rx_start = 1'b0;
            c0 = cycleCnt;
            e.kind  = 2;
            e.data  = lastGood;
            e.cycle = c0 + 4;
            expQ.push_back(e);
            repeat (3) @(negedge clk);
            checkOutput("to_still_waiting", master_ready, 1);
            @(negedge clk);
            checkOutput("to_master_ready", master_ready, 0);
            checkOutput("to_busy", busy, 0);
        end
`else
        $display("[TB] long handshake wait, no timeout");
        applyStimulus(8'h5A, 7, -1, -1, 0, 0, 20);
`endif

        repeat (3) @(negedge clk);
        checkOutput("final_busy", busy, 0);
        checkOutput("final_data_out", data_out, lastGood);
        checkOutput("queue_drained", expQ.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/master_in_port.md
Name: master_in_port

Overview:
Master-side serial receive port of the system bus; the far end of the slave serial transmit port.
- Waits for a master-core read request, then raises master_ready.
- Completes the handshake with slave_ready.
- Deserialises DATA_WIDTH bits, LSB first, one bit per clock.
- Presents the received word with a one-cycle valid pulse, and checks the slave's done strobe for framing.

Parameters:
DATA_WIDTH, 8, bits per serial frame.
TIMEOUT_CYCLES, 255, maximum cycles in WAIT_HS before abort. Used only with MASTER_IN_TIMEOUT_EN.

Ports:
clk  in  1  system clock; all state updates on rising edge.
reset  in  1  asynchronous, active-high reset.
rx_start  in  1  master core requests one frame; sampled only in IDLE.
slave_ready  in  1  slave has data (slave's data_ready).
rx_data  in  1  serial bit from slave (slave's tx_data).
slave_tx_done  in  1  slave marks the last bit.
master_ready  out  1  registered; high only in WAIT_HS.
busy  out  1  high in any state other than IDLE.
data_out  out  DATA_WIDTH  last good word; holds until the next good frame.
data_valid  out  1  one-cycle pulse when data_out updates.
frame_err  out  1  one-cycle pulse on a framing violation.
timeout_err  out  1  one-cycle pulse on handshake timeout. Tied 0 without the macro.

Behaviour:
- Reset (async, any state): state=IDLE, all outputs 0, shift register 0, bit counter 0. A partial frame is discarded.
- States: IDLE, WAIT_HS, RECEIVE.
- IDLE:
  - rx_start=1 -> WAIT_HS; master_ready<=1 at the same edge.
  - Otherwise stay.
- WAIT_HS:
  - Handshake edge H is the edge where slave_ready & master_ready = 1.
  - At H: -> RECEIVE, master_ready<=0, bit_cnt<=0.
  - rx_start is ignored here.
- RECEIVE:
  - Edges H+1 .. H+DATA_WIDTH sample rx_data into shift[bit_cnt], then bit_cnt++. Bit 0 is sampled at H+1.
  - At edges H+1 .. H+DATA_WIDTH-1, slave_tx_done=1 is an early done -> frame_err pulse, shift discarded, -> IDLE immediately.
  - At edge H+DATA_WIDTH, slave_tx_done must be 1:
    - If 1: data_out<=assembled word, data_valid<=1 for one cycle, -> IDLE.
    - If 0: frame_err pulse, data_out unchanged, -> IDLE.
- Latency: data_valid is high in the cycle after edge H+DATA_WIDTH, i.e. DATA_WIDTH+1 cycles after the handshake cycle.
- Back-to-back: from IDLE, a new rx_start can be accepted in the cycle data_valid is high.
- busy is combinational from state (state != IDLE).
- Counter width is clog2(DATA_WIDTH)+1; no wrap inside a frame.
- slave_ready dropping during RECEIVE is ignored.
- data_valid and frame_err are never high together.

Optional Feature:
MASTER_IN_TIMEOUT_EN
- Defined:
  - A counter runs in WAIT_HS.
  - If TIMEOUT_CYCLES edges elapse with no handshake: master_ready<=0, timeout_err pulses one cycle, -> IDLE.
  - A handshake on the same edge the count expires wins; no timeout is raised.
- Undefined:
  - WAIT_HS waits indefinitely.
  - timeout_err is constant 0, and no counter logic exists.

Decomposition:
- Shared package bus_pkg holds:
  - the state encoding constants (IDLE, WAIT_HS, RECEIVE);
  - the DATA_WIDTH default;
  - the TIMEOUT_CYCLES default.
  The slave transmit port uses the same frame width constant.
- One sub-module is natural: serial_shift_in, a DATA_WIDTH LSB-first shift register with load-enable and clear, plus its bit counter. The FSM stays in the top module.

Test Plan:
1. Nominal frame:
   - Stimulus: rx_start pulse; slave_ready=1 two cycles later; rx_data serialises 8'hA5 LSB first; slave_tx_done=1 with bit 7.
   - Required: data_out=8'hA5, data_valid one cycle at H+9, frame_err=0.
2. Early done:
   - Stimulus: slave_tx_done=1 with bit 3 of 8'h3C.
   - Required: frame_err pulse; IDLE at the next cycle; data_out keeps its previous value (8'hA5).
3. Missing done:
   - Stimulus: slave_tx_done stays 0 through bit 7.
   - Required: frame_err pulse, no data_valid.
4. Reset mid-frame:
   - Stimulus: assert reset after bit 4 of 8'hFF; then a fresh 8'h01 frame.
   - Required: all outputs 0 immediately on reset; the fresh frame yields 8'h01 with no stale bits.
5. Back-to-back and ignored request:
   - Stimulus: frames 8'h55 then 8'hAA, with rx_start reasserted in the data_valid cycle; an extra rx_start mid-frame.
   - Required: both words delivered; the mid-frame rx_start has no effect.
6. With MASTER_IN_TIMEOUT_EN, TIMEOUT_CYCLES=4:
   - Stimulus: rx_start with slave_ready held 0.
   - Required: timeout_err pulse 4 cycles after entering WAIT_HS; master_ready=0; state IDLE.
